// File: rtl/meas_scheduler.sv
// rtl/meas_scheduler.sv - frequency-measurement sequencer: mode select, settle, gated edge count
module meas_scheduler #(
    parameter int GATE_CYCLES   = 100_000_000,
    parameter int SETTLE_CYCLES = 64,
    parameter int COUNT_W       = 16
) (
    input  logic               i_sysclk,
    input  logic               i_reset,
    input  logic               i_auto_en,
    input  logic [1:0]         i_sw_mode,
    input  logic               i_sigin,
    output logic [1:0]         o_testmode,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_count_valid,
    output logic               o_overflow,
    output logic               o_busy
);

    // One timer serves both phases, so it is sized for the longer one.
    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX     = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE     = COUNT_W'(1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_GATE   = 2'd1,
        ST_LATCH  = 2'd2
    } state_t;

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic [COUNT_W-1:0]  r_edge_cnt;
    logic                r_ovf;
    logic [1:0]          r_testmode;
    logic [COUNT_W-1:0]  r_count;
    logic                r_count_valid;
    logic                r_overflow;
    logic                r_busy;

    logic                r_s1;
    logic                r_s2;
    logic                r_s3;

    logic                w_rise;
    logic                w_override;
    logic                w_at_max;
    logic [COUNT_W-1:0]  w_cnt_next;
    logic                w_ovf_next;

    // Two-flop synchronizer for the asynchronous generator output, plus one flop for edge detect.
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_sigin;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Switch change in manual mode restarts the measurement; LATCH itself is never interrupted.
    assign w_override = ~i_auto_en & (i_sw_mode != r_testmode) & (r_state != ST_LATCH);

    // Saturating edge counter; ovf records an increment attempted while already at full scale.
    assign w_at_max   = (r_edge_cnt == CNT_MAX);
    assign w_cnt_next = (w_rise && !w_at_max) ? (r_edge_cnt + CNT_ONE) : r_edge_cnt;
    assign w_ovf_next = r_ovf | (w_rise & w_at_max);

    // Measurement sequencer: settle after a mode change, gate and count, publish the result.
    always_ff @(posedge i_sysclk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_SETTLE;
            r_timer       <= '0;
            r_edge_cnt    <= '0;
            r_ovf         <= 1'b0;
            r_testmode    <= 2'b00;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                ST_SETTLE: begin
                    if (w_override) begin
                        r_testmode <= i_sw_mode;
                        r_timer    <= '0;
                    end else if (r_timer == SETTLE_LAST) begin
                        r_state    <= ST_GATE;
                        r_timer    <= '0;
                        r_edge_cnt <= '0;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_ONE;
                    end
                end
                ST_GATE: begin
                    if (w_override) begin
                        r_testmode <= i_sw_mode;
                        r_state    <= ST_SETTLE;
                        r_timer    <= '0;
                    end else begin
                        r_edge_cnt <= w_cnt_next;
                        r_ovf      <= w_ovf_next;
                        if (r_timer == GATE_LAST) begin
                            // Result is taken from the next-count so a rise on the final gate cycle is kept.
                            r_state       <= ST_LATCH;
                            r_timer       <= '0;
                            r_count       <= w_cnt_next;
                            r_overflow    <= w_ovf_next;
                            r_count_valid <= 1'b1;
                            r_busy        <= 1'b0;
                        end else begin
                            r_timer <= r_timer + TMR_ONE;
                        end
                    end
                end
                ST_LATCH: begin
                    if (i_auto_en) begin
                        r_testmode <= r_testmode + 2'd1;
                    end else begin
                        r_testmode <= i_sw_mode;
                    end
                    r_state <= ST_SETTLE;
                    r_timer <= '0;
                    r_busy  <= 1'b1;
                end
                default: begin
                    r_state <= ST_SETTLE;
                    r_timer <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_testmode    = r_testmode;
    assign o_count       = r_count;
    assign o_count_valid = r_count_valid;
    assign o_overflow    = r_overflow;
    assign o_busy        = r_busy;

endmodule
